aespim_cmd_sequencer: RTL and testbench

AESPIM_CMD_SEQUENCER -- requirements
Module: aespim_cmd_sequencer

---
 rtl/aespim_cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_aespim_cmd_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aespim_cmd_sequencer.sv
// Command sequencer for an AES-style accelerator: loads a 128-bit key, issues
// key-expansion commands, then waits for the result or a timeout.
module aespim_cmd_sequencer #(
    parameter int NUM_KEX = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] req_key_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [31:0]  rsp_data_o,
    output logic         rsp_err_o,
    output logic         acc_start_o,
    output logic [2:0]   acc_op_code_o,
    output logic [31:0]  acc_data_o,
    input  logic [31:0]  acc_data_i,
    input  logic         acc_done_i
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KEXR,
        KEX,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_KEXR = 3'b010;
    localparam logic [2:0] OP_KEX  = 3'b011;
    localparam logic [3:0] KEX_LAST = 4'(NUM_KEX - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

    state_t       state;
    logic [3:0]   cnt;
    logic [7:0]   timer;
    logic [127:0] key;

    function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] w);
        case (w)
            2'd0:    key_word = k[31:0];
            2'd1:    key_word = k[63:32];
            2'd2:    key_word = k[95:64];
            default: key_word = k[127:96];
        endcase
    endfunction

    // Outputs are registered one cycle ahead: each transition loads the values
    // the next state must present, so commands stream with no gaps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            timer         <= 8'd0;
            key           <= '0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= 32'd0;
            rsp_err_o     <= 1'b0;
            acc_start_o   <= 1'b0;
            acc_op_code_o <= OP_LD;
            acc_data_o    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        key           <= req_key_i;
                        cnt           <= 4'd0;
                        state         <= LOAD;
                        req_ready_o   <= 1'b0;
                        acc_start_o   <= 1'b1;
                        acc_op_code_o <= OP_LD;
                        acc_data_o    <= req_key_i[127:96];
                    end
                end
                LOAD: begin
                    // Load order is word 3 first, then 0, 1, 2: load k+1 carries word k.
                    if (cnt == 4'd3) begin
                        cnt           <= 4'd0;
                        state         <= KEXR;
                        acc_op_code_o <= OP_KEXR;
                        acc_data_o    <= 32'd0;
                    end else begin
                        cnt        <= cnt + 4'd1;
                        acc_data_o <= key_word(key, cnt[1:0]);
                    end
                end
                KEXR: begin
                    cnt           <= 4'd0;
                    state         <= KEX;
                    acc_op_code_o <= OP_KEX;
                end
                KEX: begin
                    if (cnt == KEX_LAST) begin
                        cnt           <= 4'd0;
                        timer         <= 8'd0;
                        state         <= WAIT;
                        acc_start_o   <= 1'b0;
                        acc_op_code_o <= OP_LD;
                        acc_data_o    <= 32'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WAIT: begin
                    if (acc_done_i) begin
                        rsp_data_o  <= acc_data_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (timer == TMO_LAST) begin
                        timer       <= TMO_MAX;
                        rsp_data_o  <= 32'd0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aespim_cmd_sequencer.sv
// Testbench for aespim_cmd_sequencer: directed and randomized transactions checked
// against a transaction-level model of the command stream and response.
module tb_aespim_cmd_sequencer;

    localparam int NUM_KEX = 4;
    localparam int TIMEOUT = 255;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [127:0] req_key_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  rsp_data_o;
    logic         rsp_err_o;
    logic         acc_start_o;
    logic [2:0]   acc_op_code_o;
    logic [31:0]  acc_data_o;
    logic [31:0]  acc_data_i;
    logic         acc_done_i;

    int checks = 0;
    int errors = 0;

    aespim_cmd_sequencer #(.NUM_KEX(NUM_KEX), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_key_i(req_key_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .acc_start_o(acc_start_o),
        .acc_op_code_o(acc_op_code_o),
        .acc_data_o(acc_data_o),
        .acc_data_i(acc_data_i),
        .acc_done_i(acc_done_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction. done_cyc is the 1-based WAIT cycle in which done is
    // raised; values outside 1..TIMEOUT mean the accelerator never answers.
    task automatic run_txn(input logic [127:0] k, input int done_cyc, input logic [31:0] dval,
                           input bit spurious, input int bp);
        int          order[4] = '{3, 0, 1, 2};
        logic [2:0]  exp_op[$];
        logic [31:0] exp_dat[$];
        bit          timed_out;
        logic [31:0] exp_rdata;
        for (int j = 0; j < 4; j++) begin
            exp_op.push_back(3'b000);
            exp_dat.push_back(k[32*order[j] +: 32]);
        end
        exp_op.push_back(3'b010);
        exp_dat.push_back(32'd0);
        for (int j = 0; j < NUM_KEX; j++) begin
            exp_op.push_back(3'b011);
            exp_dat.push_back(32'd0);
        end
        timed_out = (done_cyc < 1) || (done_cyc > TIMEOUT);
        exp_rdata = timed_out ? 32'd0 : dval;

        chk("idle_req_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_key_i   = k;
        step();
        req_valid_i = 1'b0;
        req_key_i   = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < exp_op.size(); i++) begin
            chk("cmd_start", acc_start_o, 1);
            chk("cmd_op", acc_op_code_o, exp_op[i]);
            chk("cmd_data", acc_data_o, exp_dat[i]);
            chk("cmd_req_ready", req_ready_o, 0);
            acc_done_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            acc_data_i = $urandom;
            step();
        end
        for (int n = 1; n <= TIMEOUT; n++) begin
            chk("wait_rsp_valid", rsp_valid_o, 0);
            chk("wait_start", acc_start_o, 0);
            chk("wait_op", acc_op_code_o, 0);
            chk("wait_data", acc_data_o, 0);
            if (n == done_cyc) begin
                acc_done_i = 1'b1;
                acc_data_i = dval;
            end else begin
                acc_done_i = 1'b0;
                acc_data_i = $urandom;
            end
            step();
            if (n == done_cyc) break;
        end
        acc_done_i = 1'b0;
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_data", rsp_data_o, exp_rdata);
        chk("rsp_err", rsp_err_o, 32'(timed_out));
        chk("rsp_req_ready", req_ready_o, 0);
        for (int i = 0; i < bp; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid_o, 1);
            chk("bp_rsp_data", rsp_data_o, exp_rdata);
            chk("bp_rsp_err", rsp_err_o, 32'(timed_out));
            chk("bp_req_ready", req_ready_o, 0);
            chk("bp_start", acc_start_o, 0);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("hs_rsp_valid", rsp_valid_o, 0);
        chk("hs_req_ready", req_ready_o, 1);
    endtask

    localparam logic [127:0] NOM_KEY = {32'h09CF4F3C, 32'hF005BA11, 32'hDECAFBAD, 32'hDEADBEEF};

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_key_i   = '0;
        rsp_ready_i = 1'b0;
        acc_data_i  = 32'd0;
        acc_done_i  = 1'b0;
        #2;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_start", acc_start_o, 0);
        chk("rst_op", acc_op_code_o, 0);
        chk("rst_data", acc_data_o, 0);
        step();
        step();
        rst_i = 1'b0;
        step();

        run_txn(NOM_KEY, 3, 32'h12345678, 1'b0, 0);
        run_txn(NOM_KEY, 5, 32'hCAFEF00D, 1'b1, 0);
        run_txn(NOM_KEY, 2, 32'hA5A55A5A, 1'b0, 10);
        run_txn(NOM_KEY, 0, 32'hFFFFFFFF, 1'b0, 1);
        run_txn(NOM_KEY, TIMEOUT, 32'h0BADCAFE, 1'b0, 0);

        // Reset during the second KEX command.
        req_valid_i = 1'b1;
        req_key_i   = NOM_KEY;
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("midkex_op", acc_op_code_o, 3'b011);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midkex_rst_start", acc_start_o, 0);
        chk("midkex_rst_op", acc_op_code_o, 0);
        chk("midkex_rst_req_ready", req_ready_o, 1);
        chk("midkex_rst_rsp_valid", rsp_valid_o, 0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_start", acc_start_o, 0);
        run_txn(NOM_KEY, 3, 32'h12345678, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            run_txn({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 40)),
                    $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
